// File: rtl/spi_cfg_master.sv
// SPI mode-0 master for the 2-bit-address / 32-bit-data config slave; one request -> one frame.
// Optional SPI_CFG_WRITE_VERIFY_EN: every write is followed by an automatic readback and compare (adds verify_err_o).
module spi_cfg_master #(
  parameter int CLK_DIV = 4,
  parameter int TA_BITS = 1,
  parameter int CS_GAP  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        busy_o,
  output logic        spi_scs_o,
  output logic        spi_sck_o,
  output logic        spi_sdo_o,
  input  logic        spi_sdi_i
`ifdef SPI_CFG_WRITE_VERIFY_EN
  ,
  output logic        verify_err_o
`endif
);

  localparam int         GAP_CYC    = CS_GAP * CLK_DIV;
  localparam logic [5:0] LAST_WR    = 6'd34;
  localparam logic [5:0] LAST_RD    = 6'(34 + TA_BITS);
  localparam logic [5:0] DATA_START = 6'(3 + TA_BITS);

  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_HOLD, ST_GAP} state_t;

  state_t      state;
  logic [7:0]  div_cnt;
  logic [5:0]  bit_cnt;
  logic [15:0] gap_cnt;
  logic [33:0] shreg;
  logic        we_q;
  logic [31:0] rd_sh;
  logic        tick;
`ifdef SPI_CFG_WRITE_VERIFY_EN
  logic [1:0]  addr_q;
  logic [31:0] wdata_q;
  logic        vrd_q;
`endif

  assign tick   = (div_cnt == 8'(CLK_DIV - 1));
  assign busy_o = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      shreg       <= '0;
      we_q        <= 1'b0;
      rd_sh       <= '0;
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      spi_scs_o   <= 1'b1;
      spi_sck_o   <= 1'b0;
      spi_sdo_o   <= 1'b0;
`ifdef SPI_CFG_WRITE_VERIFY_EN
      addr_q       <= '0;
      wdata_q      <= '0;
      vrd_q        <= 1'b0;
      verify_err_o <= 1'b0;
`endif
    end else begin
      rsp_valid_o <= 1'b0;
      if (state == ST_IDLE) div_cnt <= '0;
      else                  div_cnt <= tick ? 8'd0 : div_cnt + 8'd1;

      case (state)
        ST_IDLE: begin
          if (req_valid_i && req_ready_o) begin
            we_q        <= req_we_i;
            shreg       <= {req_addr_i, req_we_i ? req_wdata_i : 32'd0};
            spi_sdo_o   <= req_we_i;
            spi_scs_o   <= 1'b0;
            req_ready_o <= 1'b0;
            bit_cnt     <= '0;
            state       <= ST_SETUP;
`ifdef SPI_CFG_WRITE_VERIFY_EN
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            vrd_q   <= 1'b0;
`endif
          end
        end
        ST_SETUP: if (tick) state <= ST_SHIFT;
        ST_SHIFT: begin
          if (tick) begin
            if (!spi_sck_o) begin
              spi_sck_o <= 1'b1;
              if (!we_q && bit_cnt >= DATA_START) rd_sh <= {rd_sh[30:0], spi_sdi_i};
            end else begin
              spi_sck_o <= 1'b0;
              if (bit_cnt == (we_q ? LAST_WR : LAST_RD)) begin
                spi_sdo_o <= 1'b0;
                state     <= ST_HOLD;
              end else begin
                bit_cnt   <= bit_cnt + 6'd1;
                spi_sdo_o <= shreg[33];
                shreg     <= {shreg[32:0], 1'b0};
              end
            end
          end
        end
        ST_HOLD: begin
          if (tick) begin
            spi_scs_o <= 1'b1;
`ifdef SPI_CFG_WRITE_VERIFY_EN
            if (we_q) begin
              // readback restarts straight from GAP, so it needs one more gap cycle than the IDLE path
              state   <= ST_GAP;
              gap_cnt <= 16'(GAP_CYC - 1);
            end else begin
              rsp_valid_o  <= 1'b1;
              rsp_rdata_o  <= rd_sh;
              verify_err_o <= vrd_q && (rd_sh != wdata_q);
`else
            begin
              rsp_valid_o <= 1'b1;
              rsp_rdata_o <= we_q ? 32'd0 : rd_sh;
`endif
              if (GAP_CYC < 2) begin
                state       <= ST_IDLE;
                req_ready_o <= 1'b1;
              end else begin
                state   <= ST_GAP;
                gap_cnt <= 16'(GAP_CYC - 2);
              end
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt != 16'd0) begin
            gap_cnt <= gap_cnt - 16'd1;
`ifdef SPI_CFG_WRITE_VERIFY_EN
          end else if (we_q) begin
            we_q      <= 1'b0;
            vrd_q     <= 1'b1;
            shreg     <= {addr_q, 32'd0};
            spi_sdo_o <= 1'b0;
            spi_scs_o <= 1'b0;
            bit_cnt   <= '0;
            div_cnt   <= '0;
            state     <= ST_SETUP;
`endif
          end else begin
            state       <= ST_IDLE;
            req_ready_o <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cfg_master.sv
// Scoreboard bench for spi_cfg_master with a behavioural SPI config slave model.
module tb_spi_cfg_master;
  localparam int CLK_DIV = 4;
  localparam int TA_BITS = 1;
  localparam int CS_GAP  = 2;
`ifdef SPI_CFG_WRITE_VERIFY_EN
  localparam int WR_LOW   = 296;
  localparam int WR_RISES = 36;
`else
  localparam int WR_LOW   = 288;
  localparam int WR_RISES = 35;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        busy;
  logic        spi_scs, spi_sck, spi_sdo;
  logic        slave_sdo;
`ifdef SPI_CFG_WRITE_VERIFY_EN
  logic        verify_err;
`endif

  always #5 clk = ~clk;

  spi_cfg_master #(.CLK_DIV(CLK_DIV), .TA_BITS(TA_BITS), .CS_GAP(CS_GAP)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .busy_o(busy),
    .spi_scs_o(spi_scs), .spi_sck_o(spi_sck), .spi_sdo_o(spi_sdo), .spi_sdi_i(slave_sdo)
`ifdef SPI_CFG_WRITE_VERIFY_EN
    , .verify_err_o(verify_err)
`endif
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  // ---------------- slave model ----------------
  logic [31:0] s_regs [2];
  logic [34:0] s_shift = '0;
  int          s_rises = 0;
  logic        s_we = 1'b0;
  logic [1:0]  s_addr = '0;
  logic [1:0]  s_wr_addr = '0;
  logic [31:0] s_wr_data = '0;
  logic        fault = 1'b0;
  logic [31:0] rd_val;

  always @(negedge spi_scs or posedge spi_sck) begin
    if (!spi_sck) begin
      s_rises = 0;
    end else if (!spi_scs) begin
      s_shift = {s_shift[33:0], spi_sdo};
      s_rises++;
      if (s_rises == 3) begin
        s_we   = s_shift[2];
        s_addr = s_shift[1:0];
      end
      if (s_rises == 35 && s_we) begin
        s_wr_addr = s_addr;
        s_wr_data = s_shift[31:0];
        if (!s_addr[1]) s_regs[s_addr[0]] = s_shift[31:0];
      end
    end
  end

  always_comb begin
    rd_val    = (s_addr[1] ? 32'd0 : s_regs[s_addr[0]]) ^ {31'd0, fault};
    slave_sdo = 1'b0;
    if (!spi_scs && !s_we && s_rises >= 3 + TA_BITS && s_rises < 35 + TA_BITS)
      slave_sdo = rd_val[34 + TA_BITS - s_rises];
  end

  // ---------------- scoreboard + frame monitor ----------------
  typedef struct { logic [31:0] rdata; logic err; } exp_t;
  exp_t sb[$];
  int cyc = 0, rsp_cnt = 0;
  int fall_cyc = 0, rise_cyc = 0, last_low = 0, last_high = 0;
  int frame_rises = 0, last_rises = 0, sck_total = 0;
  logic scs_d = 1'b1, sck_d = 1'b0, rsp_d = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst_n) begin
      if (rsp_valid) begin
        rsp_cnt++;
        if (rsp_d) check("rsp_pulse_width", 32'(rsp_d), 32'd0);
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL rsp_unexpected: got rdata=%h want no response", rsp_rdata);
        end else begin
          e = sb.pop_front();
          check("rsp_rdata", rsp_rdata, e.rdata);
`ifdef SPI_CFG_WRITE_VERIFY_EN
          check("rsp_verify_err", 32'(verify_err), 32'(e.err));
`endif
        end
      end
      if (scs_d && !spi_scs) begin
        last_high   = cyc - rise_cyc;
        fall_cyc    = cyc;
        frame_rises = 0;
      end
      if (!scs_d && spi_scs) begin
        last_low   = cyc - fall_cyc;
        last_rises = frame_rises;
        rise_cyc   = cyc;
      end
      if (!sck_d && spi_sck) begin
        frame_rises++;
        sck_total++;
      end
    end
    scs_d = spi_scs;
    sck_d = spi_sck;
    rsp_d = rsp_valid;
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_wr(input logic [1:0] a, input logic [31:0] d);
    exp_t e;
`ifdef SPI_CFG_WRITE_VERIFY_EN
    e.rdata = a[1] ? 32'd0 : (d ^ {31'd0, fault});
    e.err   = (e.rdata != d);
`else
    e.rdata = 32'd0;
    e.err   = 1'b0;
`endif
    sb.push_back(e);
  endtask

  task automatic push_rd(input logic [31:0] v);
    exp_t e;
    e.rdata = v;
    e.err   = 1'b0;
    sb.push_back(e);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("ready_timeout", 32'(req_ready), 32'd1);
  endtask

  task automatic issue(input logic we, input logic [1:0] a, input logic [31:0] d);
    wait_ready();
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic finish_frame(input int target);
    int n = 0;
    while (rsp_cnt < target && n < 5000) begin
      @(negedge clk);
      n++;
    end
    wait_ready();
    @(negedge clk);
    check("rsp_count", 32'(rsp_cnt), 32'(target));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n;
    s_regs[0] = 32'd0;
    s_regs[1] = 32'hDEAD_BEEF;

    // reset state and quiet SCK after release
    repeat (3) @(negedge clk);
    check("rst_scs", 32'(spi_scs), 32'd1);
    check("rst_sck", 32'(spi_sck), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_sdo", 32'(spi_sdo), 32'd0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_no_sck", 32'(sck_total), 32'd0);

    // write addr 0
    push_wr(2'd0, 32'h8012_3456);
    issue(1'b1, 2'd0, 32'h8012_3456);
    repeat (10) @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    check("mid_ready", 32'(req_ready), 32'd0);
    check("mid_scs", 32'(spi_scs), 32'd0);
    finish_frame(1);
    check("wr0_slave_data", s_regs[0], 32'h8012_3456);
    check("wr0_slave_addr", 32'(s_wr_addr), 32'd0);
    check("wr0_scs_low", 32'(last_low), 32'(WR_LOW));
    check("wr0_sck_rises", 32'(last_rises), 32'(WR_RISES));

    // read addr 1
    push_rd(32'hDEAD_BEEF);
    issue(1'b0, 2'd1, 32'h0);
    finish_frame(2);
    check("rd1_scs_low", 32'(last_low), 32'd296);
    check("rd1_sck_rises", 32'(last_rises), 32'd36);
    repeat (5) @(negedge clk);
    check("rd1_rdata_held", rsp_rdata, 32'hDEAD_BEEF);

    // back-to-back write then read with valid held
    push_wr(2'd1, 32'h0000_00A5);
    push_rd(32'h0000_00A5);
    wait_ready();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 2'd1; req_wdata = 32'h0000_00A5;
    @(negedge clk);
    req_we = 1'b0; req_wdata = 32'h0;
    wait_ready();
    @(negedge clk);
    req_valid = 1'b0;
    finish_frame(4);
    check("b2b_gap", 32'(last_high), 32'(CS_GAP * CLK_DIV));
    check("b2b_slave_data", s_regs[1], 32'h0000_00A5);

    // async reset at bit 20 of a write
    base = rsp_cnt;
    issue(1'b1, 2'd0, 32'hFFFF_FFFF);
    n = 0;
    while (s_rises != 20 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached_bit20", 32'(s_rises), 32'd20);
    #1 rst_n = 1'b0;
    #1;
    check("abort_scs", 32'(spi_scs), 32'd1);
    check("abort_sck", 32'(spi_sck), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_no_rsp", 32'(rsp_cnt), 32'(base));
    check("abort_slave_kept", s_regs[0], 32'h8012_3456);
    push_wr(2'd0, 32'h0000_0001);
    issue(1'b1, 2'd0, 32'h0000_0001);
    finish_frame(base + 1);
    check("post_abort_data", s_regs[0], 32'h0000_0001);

    // read-back of addr 0, reserved-address read and write
    push_rd(32'h0000_0001);
    issue(1'b0, 2'd0, 32'h0);
    finish_frame(base + 2);
    push_rd(32'h0);
    issue(1'b0, 2'd2, 32'h0);
    finish_frame(base + 3);
    check("rd2_addr_sent", 32'(s_addr), 32'd2);
    push_wr(2'd3, 32'h0000_0F0F);
    issue(1'b1, 2'd3, 32'h0000_0F0F);
    finish_frame(base + 4);
    check("wr3_addr_sent", 32'(s_wr_addr), 32'd3);
    check("wr3_data_sent", s_wr_data, 32'h0000_0F0F);

`ifdef SPI_CFG_WRITE_VERIFY_EN
    // readback with a corrupted bit 0
    base = rsp_cnt;
    fault = 1'b1;
    push_wr(2'd1, 32'h1234_5678);
    issue(1'b1, 2'd1, 32'h1234_5678);
    finish_frame(base + 1);
    repeat (20) @(negedge clk);
    check("verify_single_rsp", 32'(rsp_cnt), 32'(base + 1));
    check("verify_err_set", 32'(verify_err), 32'd1);
    fault = 1'b0;
    push_wr(2'd1, 32'h0000_0055);
    issue(1'b1, 2'd1, 32'h0000_0055);
    finish_frame(base + 2);
    check("verify_err_clear", 32'(verify_err), 32'd0);
`endif

    repeat (10) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
